// File: rtl/ifd4_pkg.sv
// Shared constants and the event record for the 4-channel input deglitcher.
// Used by ifd4_sync and ifd1_deglitch.
package ifd4_pkg;
  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 4;
  localparam int GLITCH_MIN = 1;
  localparam int GLITCH_MAX = 15;

  typedef struct packed {
    logic              vld;
    logic [NUM_CH-1:0] data;
  } ev_t;
endpackage

// File: rtl/ifd1_deglitch.sv
// One channel: two-flop synchronizer, optional persistence counter
// (IFD4_SYNC_DEGLITCH_EN), registered level Q and edge pulses.
module ifd1_deglitch
  import ifd4_pkg::*;
#(
  parameter int GLITCH_CYC = 3
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic d,
  output logic q,
  output logic q_nxt,
  output logic rise,
  output logic fall
);

  if (GLITCH_CYC < GLITCH_MIN || GLITCH_CYC > GLITCH_MAX) begin : g_bad_cfg
    $error("ifd1_deglitch: GLITCH_CYC out of range");
  end

  logic s1_q, s2_q, q_q, rise_q, fall_q;
  logic q_d, rise_d, fall_d;

`ifdef IFD4_SYNC_DEGLITCH_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only survives while s2 keeps disagreeing with Q; it is
  // cleared on the load edge as well as on any agreeing cycle.
  always_comb begin
    cnt_d = '0;
    q_d   = q_q;
    if (s2_q != q_q) begin
      if (cnt_q == CNT_W'(GLITCH_CYC - 1)) q_d = s2_q;
      else                                 cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge gclk) begin
    if (!grst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  always_comb q_d = s2_q;
`endif

  always_comb begin
    rise_d = q_d & ~q_q;
    fall_d = ~q_d & q_q;
  end

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      q_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q     = q_q;
  assign q_nxt = q_d;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ifd4_sync.sv
// 4-channel synchronizer/deglitcher with a single-entry change-event slot
// and sticky overflow. Deglitch counters enabled by IFD4_SYNC_DEGLITCH_EN.
module ifd4_sync
  import ifd4_pkg::*;
#(
  parameter int GLITCH_CYC = 3
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic [NUM_CH-1:0] D,
  output logic [NUM_CH-1:0] Q,
  output logic [NUM_CH-1:0] RISE,
  output logic [NUM_CH-1:0] FALL,
  output logic              EV_VALID,
  output logic [NUM_CH-1:0] EV_DATA,
  input  logic              EV_READY,
  output logic              OVF,
  input  logic              OVF_CLR
);

  logic [NUM_CH-1:0] q_w, q_nxt_w;
  logic              chg;
  ev_t               ev_q, ev_d;
  logic              ovf_q, ovf_d;

  ifd1_deglitch #(.GLITCH_CYC(GLITCH_CYC)) u_ch [NUM_CH-1:0] (
    .gclk   (CK),
    .grst_n (RSTN),
    .d      (D),
    .q      (q_w),
    .q_nxt  (q_nxt_w),
    .rise   (RISE),
    .fall   (FALL)
  );

  // Event is captured on the same edge Q changes, so EV_DATA and the new Q
  // become visible together.
  assign chg = |(q_nxt_w ^ q_w);

  always_comb begin
    ev_d  = ev_q;
    ovf_d = OVF_CLR ? 1'b0 : ovf_q;
    if (ev_q.vld && EV_READY) ev_d.vld = 1'b0;
    if (chg) begin
      if (!ev_q.vld || EV_READY) begin
        ev_d.vld  = 1'b1;
        ev_d.data = q_nxt_w;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      ev_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      ev_q  <= ev_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q        = q_w;
  assign EV_VALID = ev_q.vld;
  assign EV_DATA  = ev_q.data;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_ifd4_sync.sv
// Self-checking bench for ifd4_sync: vector table, corner sequences and a
// randomized run against a history-window reference model.
module tb_ifd4_sync;
  localparam int G = 3;
`ifdef IFD4_SYNC_DEGLITCH_EN
  localparam int LAT = 1 + G;
`else
  localparam int LAT = 2;
`endif

  logic       CK = 1'b0;
  logic       RSTN, EV_READY, OVF_CLR;
  logic [3:0] D;
  logic [3:0] Q, RISE, FALL, EV_DATA;
  logic       EV_VALID, OVF;

  ifd4_sync #(.GLITCH_CYC(G)) dut (
    .CK(CK), .RSTN(RSTN), .D(D), .Q(Q), .RISE(RISE), .FALL(FALL),
    .EV_VALID(EV_VALID), .EV_DATA(EV_DATA), .EV_READY(EV_READY),
    .OVF(OVF), .OVF_CLR(OVF_CLR)
  );

  always #5 CK = ~CK;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: D sampled at each edge kept by edge number; Q flips when
  // the synchronized value has disagreed for the last G cycles since Q's
  // last change (or reset).
  logic [3:0] hist [0:8191];
  int         last_l [4];
  int         e;
  logic [3:0] m_q, m_rise, m_fall, m_evd;
  logic       m_evv, m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [3:0] d, input logic rstn, input logic rdy, input logic clr);
    logic [3:0] nq;
    bit         ovf_set;
    e++;
    if (!rstn) begin
      hist[e] = 4'b0; hist[e-1] = 4'b0;
      for (int n = 0; n < 4; n++) last_l[n] = e;
      m_q = 0; m_rise = 0; m_fall = 0; m_evd = 0; m_evv = 0; m_ovf = 0;
      return;
    end
    hist[e] = d;
`ifdef IFD4_SYNC_DEGLITCH_EN
    nq = m_q;
    for (int n = 0; n < 4; n++) begin
      if (e >= last_l[n] + G) begin
        bit ok = 1;
        for (int x = e - G + 1; x <= e; x++)
          if (hist[x-2][n] == m_q[n]) ok = 0;
        if (ok) begin
          nq[n] = ~m_q[n];
          last_l[n] = e;
        end
      end
    end
`else
    nq = hist[e-2];
`endif
    m_rise = nq & ~m_q;
    m_fall = ~nq & m_q;
    ovf_set = 0;
    if (nq != m_q) begin
      if (!m_evv || rdy) begin m_evv = 1; m_evd = nq; end
      else ovf_set = 1;
    end else if (m_evv && rdy) m_evv = 0;
    m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_q = nq;
  endtask

  task automatic step(input logic [3:0] d, input logic rstn, input logic rdy, input logic clr);
    D = d; RSTN = rstn; EV_READY = rdy; OVF_CLR = clr;
    model_edge(d, rstn, rdy, clr);
    @(posedge CK);
    #1;
    check("model", 32'({Q, RISE, FALL, EV_VALID, EV_DATA, OVF}),
          32'({m_q, m_rise, m_fall, m_evv, m_evd, m_ovf}));
  endtask

  typedef struct {
    logic [3:0] d;
    logic       rdy, clr;
    int         ncyc;
    logic [3:0] q, rise, fall, evd;
    logic       evv, ovf;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int hs, rc, fc;
    logic [3:0] dr;
    for (int i = 0; i < 8192; i++) hist[i] = 4'b0;
    e = 16;
    for (int n = 0; n < 4; n++) last_l[n] = e;
    m_q = 0; m_rise = 0; m_fall = 0; m_evd = 0; m_evv = 0; m_ovf = 0;

    //          d        rdy   clr   ncyc   q        rise     fall     evd      evv   ovf
    tbl[0] = '{4'b0001, 1'b0, 1'b0, LAT+1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0};
    tbl[1] = '{4'b0011, 1'b0, 1'b0, LAT+1, 4'b0011, 4'b0010, 4'b0000, 4'b0001, 1'b1, 1'b1};
    tbl[2] = '{4'b0011, 1'b0, 1'b1, 1,     4'b0011, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0};
    tbl[3] = '{4'b0011, 1'b1, 1'b0, 1,     4'b0011, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0};
    tbl[4] = '{4'b0010, 1'b1, 1'b0, LAT+1, 4'b0010, 4'b0000, 4'b0001, 4'b0010, 1'b1, 1'b0};
    tbl[5] = '{4'b0010, 1'b1, 1'b0, 1,     4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0};
    tbl[6] = '{4'b1111, 1'b0, 1'b0, LAT+1, 4'b1111, 4'b1101, 4'b0000, 4'b1111, 1'b1, 1'b0};
    tbl[7] = '{4'b0000, 1'b1, 1'b0, LAT+1, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0};
    tbl[8] = '{4'b0000, 1'b0, 1'b0, 1,     4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};

    // Reset state
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    check("reset", 32'({Q, RISE, FALL, EV_VALID, EV_DATA, OVF}), 32'd0);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      for (int c = 0; c < tbl[i].ncyc; c++) step(tbl[i].d, 1'b1, tbl[i].rdy, tbl[i].clr);
      check($sformatf("tbl%0d", i), 32'({Q, RISE, FALL, EV_VALID, EV_DATA, OVF}),
            32'({tbl[i].q, tbl[i].rise, tbl[i].fall, tbl[i].evv, tbl[i].evd, tbl[i].ovf}));
    end

    // Reset mid-count with an event pending, D stays high through release
    for (int i = 0; i < LAT; i++) step(4'b0001, 1'b1, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    check("rst_mid", 32'({Q, RISE, FALL, EV_VALID, EV_DATA, OVF}), 32'd0);
    for (int i = 0; i < LAT; i++) step(4'b0001, 1'b1, 1'b0, 1'b0);
    check("rel_early_q", 32'(Q), 32'd0);
    step(4'b0001, 1'b1, 1'b0, 1'b0);
    check("rel_q", 32'({Q, RISE, EV_VALID, EV_DATA}), 32'({4'b0001, 4'b0001, 1'b1, 4'b0001}));

    // Short pulse on channel 2
    step(4'b0000, 1'b0, 1'b1, 1'b0);
`ifdef IFD4_SYNC_DEGLITCH_EN
    for (int i = 0; i < 10; i++) begin
      step((i < 2) ? 4'b0100 : 4'b0000, 1'b1, 1'b1, 1'b0);
      check("glitch", 32'({Q, RISE, FALL, EV_VALID}), 32'd0);
    end
`else
    rc = 0; fc = 0;
    for (int i = 0; i < 7; i++) begin
      step((i == 0) ? 4'b0100 : 4'b0000, 1'b1, 1'b1, 1'b0);
      check("pulse_q", 32'(Q), (i == 2) ? 32'h4 : 32'h0);
      rc += int'(RISE[2]);
      fc += int'(FALL[2]);
    end
    check("pulse_rise", 32'(rc), 32'd1);
    check("pulse_fall", 32'(fc), 32'd1);
`endif

    // Back-to-back events with READY held high
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    hs = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      step((i == 0) ? 4'b0001 : 4'b0011, 1'b1, 1'b1, 1'b0);
      hs += int'(EV_VALID);
      if (i == LAT)     check("b2b_ev0", 32'({EV_VALID, EV_DATA}), 32'({1'b1, 4'b0001}));
      if (i == LAT + 1) check("b2b_ev1", 32'({EV_VALID, EV_DATA}), 32'({1'b1, 4'b0011}));
      if (i == LAT + 2) check("b2b_idle", 32'(EV_VALID), 32'd0);
    end
    check("b2b_hs", 32'(hs), 32'd2);

    // Randomized run against the model
    dr = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 4; n++)
        if ($urandom_range(0, 5) == 0) dr[n] = ~dr[n];
      step(dr, ($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
